// File: rtl/mask_centroid_acc.sv
// mask_centroid_acc: consumes the binary mask stream and accumulates per-frame foreground count and x/y sums.
// Define MASK_CENTROID_BBOX_EN to also report the per-frame foreground bounding box.
module mask_centroid_acc #(
   parameter  int IMG_W = 32,
   parameter  int IMG_H = 32,
   parameter  int CNT_W = 11,
   parameter  int SUM_W = 20,
   localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1,
   localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_rst_n,
   output logic             mask_fifo_rd_en,
   input  logic [7:0]       mask_fifo_dout,
   input  logic             mask_fifo_empty,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [CNT_W-1:0] res_count,
   output logic [SUM_W-1:0] res_sum_x,
   output logic [SUM_W-1:0] res_sum_y,
   output logic [7:0]       res_frame_id,
`ifdef MASK_CENTROID_BBOX_EN
   output logic [XW-1:0]    res_xmin,
   output logic [XW-1:0]    res_xmax,
   output logic [YW-1:0]    res_ymin,
   output logic [YW-1:0]    res_ymax,
`endif
   output logic             busy
);

   // Result handshake: res_* are held stable while res_valid=1; the record is
   // transferred on the edge where res_valid & res_ready, which clears res_valid.

   logic [XW-1:0]    x_q, x_d;
   logic [YW-1:0]    y_q, y_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SUM_W-1:0] sx_q, sx_d;
   logic [SUM_W-1:0] sy_q, sy_d;
   logic [7:0]       fid_q, fid_d;
   logic             rd_pending_q, rd_pending_d;
   logic             res_valid_q, res_valid_d;
   logic [CNT_W-1:0] res_count_q, res_count_d;
   logic [SUM_W-1:0] res_sum_x_q, res_sum_x_d;
   logic [SUM_W-1:0] res_sum_y_q, res_sum_y_d;
   logic [7:0]       res_frame_id_q, res_frame_id_d;

   logic             hold;
   logic             fg;
   logic             x_last;
   logic             y_last;
   logic             frame_end;
   logic [CNT_W-1:0] cnt_inc;
   logic [SUM_W-1:0] sx_inc;
   logic [SUM_W-1:0] sy_inc;

`ifdef MASK_CENTROID_BBOX_EN
   logic [XW-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
   logic [YW-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
   logic [XW-1:0] res_xmin_q, res_xmin_d, res_xmax_q, res_xmax_d;
   logic [YW-1:0] res_ymin_q, res_ymin_d, res_ymax_q, res_ymax_d;
   logic [XW-1:0] xmin_inc, xmax_inc;
   logic [YW-1:0] ymin_inc, ymax_inc;
`endif

   assign hold = res_valid_q & ~res_ready;
   // Reads are suppressed during either reset so no byte is pulled and then dropped.
   assign mask_fifo_rd_en = rst_n & s_rst_n & ~mask_fifo_empty & ~hold;

   assign fg        = rd_pending_q & (mask_fifo_dout != 8'd0);
   assign x_last    = (x_q == XW'(IMG_W - 1));
   assign y_last    = (y_q == YW'(IMG_H - 1));
   assign frame_end = rd_pending_q & x_last & y_last;

   assign cnt_inc = cnt_q + CNT_W'(fg);
   assign sx_inc  = fg ? (sx_q + SUM_W'(x_q)) : sx_q;
   assign sy_inc  = fg ? (sy_q + SUM_W'(y_q)) : sy_q;

`ifdef MASK_CENTROID_BBOX_EN
   assign xmin_inc = (fg && (x_q < xmin_q)) ? x_q : xmin_q;
   assign xmax_inc = (fg && (x_q > xmax_q)) ? x_q : xmax_q;
   assign ymin_inc = (fg && (y_q < ymin_q)) ? y_q : ymin_q;
   assign ymax_inc = (fg && (y_q > ymax_q)) ? y_q : ymax_q;
`endif

   always_comb begin
      x_d            = x_q;
      y_d            = y_q;
      cnt_d          = cnt_q;
      sx_d           = sx_q;
      sy_d           = sy_q;
      fid_d          = fid_q;
      rd_pending_d   = mask_fifo_rd_en;
      res_valid_d    = res_valid_q;
      res_count_d    = res_count_q;
      res_sum_x_d    = res_sum_x_q;
      res_sum_y_d    = res_sum_y_q;
      res_frame_id_d = res_frame_id_q;
`ifdef MASK_CENTROID_BBOX_EN
      xmin_d     = xmin_q;
      xmax_d     = xmax_q;
      ymin_d     = ymin_q;
      ymax_d     = ymax_q;
      res_xmin_d = res_xmin_q;
      res_xmax_d = res_xmax_q;
      res_ymin_d = res_ymin_q;
      res_ymax_d = res_ymax_q;
`endif

      if (res_valid_q && res_ready) begin
         res_valid_d = 1'b0;
      end

      if (rd_pending_q) begin
         cnt_d = cnt_inc;
         sx_d  = sx_inc;
         sy_d  = sy_inc;
`ifdef MASK_CENTROID_BBOX_EN
         xmin_d = xmin_inc;
         xmax_d = xmax_inc;
         ymin_d = ymin_inc;
         ymax_d = ymax_inc;
`endif
         if (x_last) begin
            x_d = '0;
            y_d = y_last ? '0 : (y_q + YW'(1));
         end else begin
            x_d = x_q + XW'(1);
         end

         // The record includes the final beat, so it is taken from the *_inc values.
         if (frame_end) begin
            res_valid_d    = 1'b1;
            res_count_d    = cnt_inc;
            res_sum_x_d    = sx_inc;
            res_sum_y_d    = sy_inc;
            res_frame_id_d = fid_q;
            fid_d          = fid_q + 8'd1;
            cnt_d          = '0;
            sx_d           = '0;
            sy_d           = '0;
`ifdef MASK_CENTROID_BBOX_EN
            res_xmin_d = xmin_inc;
            res_xmax_d = xmax_inc;
            res_ymin_d = ymin_inc;
            res_ymax_d = ymax_inc;
            xmin_d     = '1;
            xmax_d     = '0;
            ymin_d     = '1;
            ymax_d     = '0;
`endif
         end
      end

      if (!s_rst_n) begin
         x_d            = '0;
         y_d            = '0;
         cnt_d          = '0;
         sx_d           = '0;
         sy_d           = '0;
         fid_d          = '0;
         rd_pending_d   = 1'b0;
         res_valid_d    = 1'b0;
         res_count_d    = '0;
         res_sum_x_d    = '0;
         res_sum_y_d    = '0;
         res_frame_id_d = '0;
`ifdef MASK_CENTROID_BBOX_EN
         xmin_d     = '1;
         xmax_d     = '0;
         ymin_d     = '1;
         ymax_d     = '0;
         res_xmin_d = '0;
         res_xmax_d = '0;
         res_ymin_d = '0;
         res_ymax_d = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q            <= '0;
         y_q            <= '0;
         cnt_q          <= '0;
         sx_q           <= '0;
         sy_q           <= '0;
         fid_q          <= '0;
         rd_pending_q   <= 1'b0;
         res_valid_q    <= 1'b0;
         res_count_q    <= '0;
         res_sum_x_q    <= '0;
         res_sum_y_q    <= '0;
         res_frame_id_q <= '0;
`ifdef MASK_CENTROID_BBOX_EN
         // Running minima start at all-ones so the first foreground pixel wins.
         xmin_q     <= '1;
         xmax_q     <= '0;
         ymin_q     <= '1;
         ymax_q     <= '0;
         res_xmin_q <= '0;
         res_xmax_q <= '0;
         res_ymin_q <= '0;
         res_ymax_q <= '0;
`endif
      end else begin
         x_q            <= x_d;
         y_q            <= y_d;
         cnt_q          <= cnt_d;
         sx_q           <= sx_d;
         sy_q           <= sy_d;
         fid_q          <= fid_d;
         rd_pending_q   <= rd_pending_d;
         res_valid_q    <= res_valid_d;
         res_count_q    <= res_count_d;
         res_sum_x_q    <= res_sum_x_d;
         res_sum_y_q    <= res_sum_y_d;
         res_frame_id_q <= res_frame_id_d;
`ifdef MASK_CENTROID_BBOX_EN
         xmin_q     <= xmin_d;
         xmax_q     <= xmax_d;
         ymin_q     <= ymin_d;
         ymax_q     <= ymax_d;
         res_xmin_q <= res_xmin_d;
         res_xmax_q <= res_xmax_d;
         res_ymin_q <= res_ymin_d;
         res_ymax_q <= res_ymax_d;
`endif
      end
   end

   assign res_valid    = res_valid_q;
   assign res_count    = res_count_q;
   assign res_sum_x    = res_sum_x_q;
   assign res_sum_y    = res_sum_y_q;
   assign res_frame_id = res_frame_id_q;
   assign busy         = (x_q != '0) | (y_q != '0);
`ifdef MASK_CENTROID_BBOX_EN
   assign res_xmin = res_xmin_q;
   assign res_xmax = res_xmax_q;
   assign res_ymin = res_ymin_q;
   assign res_ymax = res_ymax_q;
`endif

endmodule

// File: tb/tb_mask_centroid_acc.sv
// tb_mask_centroid_acc: directed checks of mask_centroid_acc against hand-computed records
// and a small raster reference model; a behavioural FIFO feeds the mask stream.
module tb_mask_centroid_acc;
   localparam int IMG_W = 32;
   localparam int IMG_H = 32;
   localparam int CNT_W = 11;
   localparam int SUM_W = 20;
   localparam int NPIX  = IMG_W * IMG_H;
   localparam int TMO   = 6000;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             s_rst_n = 1'b1;
   logic             mask_fifo_rd_en;
   logic [7:0]       mask_fifo_dout;
   logic             mask_fifo_empty;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic [CNT_W-1:0] res_count;
   logic [SUM_W-1:0] res_sum_x;
   logic [SUM_W-1:0] res_sum_y;
   logic [7:0]       res_frame_id;
   logic             busy;
`ifdef MASK_CENTROID_BBOX_EN
   logic [4:0] res_xmin, res_xmax, res_ymin, res_ymax;
`endif

   mask_centroid_acc #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
      .clk(clk), .rst_n(rst_n), .s_rst_n(s_rst_n),
      .mask_fifo_rd_en(mask_fifo_rd_en), .mask_fifo_dout(mask_fifo_dout),
      .mask_fifo_empty(mask_fifo_empty),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_count(res_count), .res_sum_x(res_sum_x), .res_sum_y(res_sum_y),
      .res_frame_id(res_frame_id),
`ifdef MASK_CENTROID_BBOX_EN
      .res_xmin(res_xmin), .res_xmax(res_xmax), .res_ymin(res_ymin), .res_ymax(res_ymax),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // behavioural FIFO with 1-cycle read latency and optional random empty gaps
   logic [7:0] fifo_q[$];
   bit         gap_en = 1'b0;
   int         rd_count = 0;
   logic [7:0] img [NPIX];

   initial begin
      bit rd;
      mask_fifo_empty = 1'b1;
      mask_fifo_dout  = 8'h00;
      forever begin
         @(negedge clk);
         rd = mask_fifo_rd_en;
         @(posedge clk);
         #1;
         if (rd) begin
            if (fifo_q.size() > 0) mask_fifo_dout = fifo_q.pop_front();
            rd_count++;
         end
         mask_fifo_empty = (fifo_q.size() == 0) || (gap_en && ($urandom_range(99) < 30));
      end
   end

   // record monitor: a record is taken when valid & ready are seen between edges
   logic [CNT_W-1:0] got_cnt[$];
   logic [SUM_W-1:0] got_sx[$];
   logic [SUM_W-1:0] got_sy[$];
   logic [7:0]       got_fid[$];
   logic [19:0]      got_bb[$];
   int               valid_cycles = 0;

   always @(negedge clk) begin
      if (res_valid === 1'b1) valid_cycles++;
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
         got_cnt.push_back(res_count);
         got_sx.push_back(res_sum_x);
         got_sy.push_back(res_sum_y);
         got_fid.push_back(res_frame_id);
`ifdef MASK_CENTROID_BBOX_EN
         got_bb.push_back({res_xmin, res_xmax, res_ymin, res_ymax});
`endif
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic clear_recs();
      got_cnt.delete(); got_sx.delete(); got_sy.delete(); got_fid.delete(); got_bb.delete();
   endtask

   task automatic push_frame();
      for (int i = 0; i < NPIX; i++) fifo_q.push_back(img[i]);
   endtask

   task automatic random_img();
      for (int i = 0; i < NPIX; i++) img[i] = ($urandom_range(3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
   endtask

   task automatic wait_records(input int n, output bit ok);
      int cyc = 0;
      while (got_cnt.size() < n && cyc < TMO) begin
         @(negedge clk);
         cyc++;
      end
      ok = (got_cnt.size() >= n);
   endtask

   task automatic pop_rec(output logic [CNT_W-1:0] c, output logic [SUM_W-1:0] sx,
                          output logic [SUM_W-1:0] sy, output logic [7:0] f, output logic [19:0] bb);
      if (got_cnt.size() > 0) begin
         c = got_cnt.pop_front(); sx = got_sx.pop_front(); sy = got_sy.pop_front(); f = got_fid.pop_front();
         bb = (got_bb.size() > 0) ? got_bb.pop_front() : 20'hx;
      end else begin
         c = 'x; sx = 'x; sy = 'x; f = 'x; bb = 'x;
      end
   endtask

   // reference: raster scan of img, bbox packed as {xmin,xmax,ymin,ymax}
   task automatic ref_model(output logic [CNT_W-1:0] c, output logic [SUM_W-1:0] sx,
                            output logic [SUM_W-1:0] sy, output logic [19:0] bb);
      int xmn = 31, xmx = 0, ymn = 31, ymx = 0;
      c = 0; sx = 0; sy = 0;
      for (int yy = 0; yy < IMG_H; yy++)
         for (int xx = 0; xx < IMG_W; xx++)
            if (img[yy*IMG_W + xx] != 8'h00) begin
               c++; sx += SUM_W'(xx); sy += SUM_W'(yy);
               if (xx < xmn) xmn = xx;
               if (xx > xmx) xmx = xx;
               if (yy < ymn) ymn = yy;
               if (yy > ymx) ymx = yy;
            end
      bb = {5'(xmn), 5'(xmx), 5'(ymn), 5'(ymx)};
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (res_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", res_valid); else n_pass++;
      n_checks++; if (res_count !== '0) $display("FAIL reset_count: got %0d expected 0", res_count); else n_pass++;
      n_checks++; if (res_sum_x !== '0) $display("FAIL reset_sum_x: got %0d expected 0", res_sum_x); else n_pass++;
      n_checks++; if (res_sum_y !== '0) $display("FAIL reset_sum_y: got %0d expected 0", res_sum_y); else n_pass++;
      n_checks++; if (res_frame_id !== 8'd0) $display("FAIL reset_frame_id: got %0d expected 0", res_frame_id); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
      n_checks++; if (mask_fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b expected 0", mask_fifo_rd_en); else n_pass++;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_zero_frame();
      bit ok; logic [CNT_W-1:0] c; logic [SUM_W-1:0] sx, sy; logic [7:0] f; logic [19:0] bb;
      clear_recs();
      res_ready = 1'b1;
      valid_cycles = 0;
      for (int i = 0; i < NPIX; i++) img[i] = 8'h00;
      push_frame();
      wait_records(1, ok);
      n_checks++; if (!ok) $display("FAIL zero_timeout: got no record, expected 1"); else n_pass++;
      repeat (4) @(negedge clk);
      pop_rec(c, sx, sy, f, bb);
      n_checks++; if (c !== 11'd0) $display("FAIL zero_count: got %0d expected 0", c); else n_pass++;
      n_checks++; if (sx !== 20'd0) $display("FAIL zero_sum_x: got %0d expected 0", sx); else n_pass++;
      n_checks++; if (sy !== 20'd0) $display("FAIL zero_sum_y: got %0d expected 0", sy); else n_pass++;
      n_checks++; if (f !== 8'd0) $display("FAIL zero_frame_id: got %0d expected 0", f); else n_pass++;
      n_checks++; if (valid_cycles != 1) $display("FAIL zero_valid_pulse: got %0d cycles expected 1", valid_cycles); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL zero_busy_after: got %b expected 0", busy); else n_pass++;
`ifdef MASK_CENTROID_BBOX_EN
      n_checks++; if (bb !== {5'd31, 5'd0, 5'd31, 5'd0}) $display("FAIL zero_bbox: got %h expected %h", bb, {5'd31, 5'd0, 5'd31, 5'd0}); else n_pass++;
`endif
   endtask

   task automatic test_full_frame();
      bit ok; logic [CNT_W-1:0] c; logic [SUM_W-1:0] sx, sy; logic [7:0] f; logic [19:0] bb;
      clear_recs();
      for (int i = 0; i < NPIX; i++) img[i] = 8'hFF;
      push_frame();
      wait_records(1, ok);
      n_checks++; if (!ok) $display("FAIL full_timeout: got no record, expected 1"); else n_pass++;
      pop_rec(c, sx, sy, f, bb);
      n_checks++; if (c !== 11'd1024) $display("FAIL full_count: got %0d expected 1024", c); else n_pass++;
      n_checks++; if (sx !== 20'd15872) $display("FAIL full_sum_x: got %0d expected 15872", sx); else n_pass++;
      n_checks++; if (sy !== 20'd15872) $display("FAIL full_sum_y: got %0d expected 15872", sy); else n_pass++;
      n_checks++; if (f !== 8'd1) $display("FAIL full_frame_id: got %0d expected 1", f); else n_pass++;
`ifdef MASK_CENTROID_BBOX_EN
      n_checks++; if (bb !== {5'd0, 5'd31, 5'd0, 5'd31}) $display("FAIL full_bbox: got %h expected %h", bb, {5'd0, 5'd31, 5'd0, 5'd31}); else n_pass++;
`endif
   endtask

   task automatic test_single_pixel();
      bit ok; logic [CNT_W-1:0] c; logic [SUM_W-1:0] sx, sy; logic [7:0] f; logic [19:0] bb;
      @(posedge clk); #1 s_rst_n = 1'b0;
      @(posedge clk); #1 s_rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (res_frame_id !== 8'd0) $display("FAIL srst_frame_id: got %0d expected 0", res_frame_id); else n_pass++;
      clear_recs();
      for (int i = 0; i < NPIX; i++) img[i] = 8'h00;
      img[7*IMG_W + 5] = 8'h01;
      push_frame();
      push_frame();
      wait_records(2, ok);
      n_checks++; if (!ok) $display("FAIL single_timeout: got %0d records expected 2", got_cnt.size()); else n_pass++;
      for (int k = 0; k < 2; k++) begin
         pop_rec(c, sx, sy, f, bb);
         n_checks++; if (c !== 11'd1) $display("FAIL single_count%0d: got %0d expected 1", k, c); else n_pass++;
         n_checks++; if (sx !== 20'd5) $display("FAIL single_sum_x%0d: got %0d expected 5", k, sx); else n_pass++;
         n_checks++; if (sy !== 20'd7) $display("FAIL single_sum_y%0d: got %0d expected 7", k, sy); else n_pass++;
         n_checks++; if (f !== 8'(k)) $display("FAIL single_frame_id%0d: got %0d expected %0d", k, f, k); else n_pass++;
`ifdef MASK_CENTROID_BBOX_EN
         n_checks++; if (bb !== {5'd5, 5'd5, 5'd7, 5'd7}) $display("FAIL single_bbox%0d: got %h expected %h", k, bb, {5'd5, 5'd5, 5'd7, 5'd7}); else n_pass++;
`endif
      end
   endtask

   task automatic test_hold();
      bit ok, stable;
      int cyc, rd0;
      logic [CNT_W-1:0] ca, cb, c, snap_c; logic [SUM_W-1:0] sxa, sya, sxb, syb, sx, sy, snap_sx, snap_sy;
      logic [7:0] f, snap_f; logic [19:0] bba, bbb, bb;
      clear_recs();
      @(posedge clk); #1 res_ready = 1'b0;
      random_img(); ref_model(ca, sxa, sya, bba); push_frame();
      random_img(); ref_model(cb, sxb, syb, bbb); push_frame();
      cyc = 0;
      while (res_valid !== 1'b1 && cyc < TMO) begin
         @(negedge clk);
         cyc++;
      end
      n_checks++; if (res_valid !== 1'b1) $display("FAIL hold_timeout: res_valid %b expected 1", res_valid); else n_pass++;
      rd0 = rd_count;
      snap_c = res_count; snap_sx = res_sum_x; snap_sy = res_sum_y; snap_f = res_frame_id;
      stable = 1'b1;
      repeat (50) begin
         @(negedge clk);
         if (res_valid !== 1'b1 || res_count !== snap_c || res_sum_x !== snap_sx ||
             res_sum_y !== snap_sy || res_frame_id !== snap_f || mask_fifo_rd_en !== 1'b0) stable = 1'b0;
      end
      n_checks++; if (!stable) $display("FAIL hold_stable: got unstable record or rd_en, expected stable"); else n_pass++;
      n_checks++; if (rd_count - rd0 > 1) $display("FAIL hold_extra_reads: got %0d expected <=1", rd_count - rd0); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL hold_busy: got %b expected 1", busy); else n_pass++;
      n_checks++; if (snap_c !== ca) $display("FAIL hold_count: got %0d expected %0d", snap_c, ca); else n_pass++;
      n_checks++; if (snap_sx !== sxa || snap_sy !== sya) $display("FAIL hold_sums: got %0d/%0d expected %0d/%0d", snap_sx, snap_sy, sxa, sya); else n_pass++;
      @(posedge clk); #1 res_ready = 1'b1;
      wait_records(2, ok);
      n_checks++; if (!ok) $display("FAIL hold_resume_timeout: got %0d records expected 2", got_cnt.size()); else n_pass++;
      pop_rec(c, sx, sy, f, bb);
      n_checks++; if (f !== 8'd2) $display("FAIL hold_a_frame_id: got %0d expected 2", f); else n_pass++;
      pop_rec(c, sx, sy, f, bb);
      n_checks++; if (c !== cb) $display("FAIL hold_b_count: got %0d expected %0d", c, cb); else n_pass++;
      n_checks++; if (sx !== sxb || sy !== syb) $display("FAIL hold_b_sums: got %0d/%0d expected %0d/%0d", sx, sy, sxb, syb); else n_pass++;
      n_checks++; if (f !== 8'd3) $display("FAIL hold_b_frame_id: got %0d expected 3", f); else n_pass++;
`ifdef MASK_CENTROID_BBOX_EN
      n_checks++; if (bb !== bbb) $display("FAIL hold_b_bbox: got %h expected %h", bb, bbb); else n_pass++;
`endif
   endtask

   task automatic test_gaps();
      bit ok; int rd0;
      logic [CNT_W-1:0] ec[3], c; logic [SUM_W-1:0] esx[3], esy[3], sx, sy; logic [7:0] f; logic [19:0] ebb[3], bb;
      clear_recs();
      rd0 = rd_count;
      gap_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         random_img(); ref_model(ec[k], esx[k], esy[k], ebb[k]); push_frame();
      end
      wait_records(3, ok);
      gap_en = 1'b0;
      n_checks++; if (!ok) $display("FAIL gaps_timeout: got %0d records expected 3", got_cnt.size()); else n_pass++;
      n_checks++; if (rd_count - rd0 != 3 * NPIX) $display("FAIL gaps_reads: got %0d expected %0d", rd_count - rd0, 3 * NPIX); else n_pass++;
      for (int k = 0; k < 3; k++) begin
         pop_rec(c, sx, sy, f, bb);
         n_checks++; if (c !== ec[k]) $display("FAIL gaps_count%0d: got %0d expected %0d", k, c, ec[k]); else n_pass++;
         n_checks++; if (sx !== esx[k] || sy !== esy[k]) $display("FAIL gaps_sums%0d: got %0d/%0d expected %0d/%0d", k, sx, sy, esx[k], esy[k]); else n_pass++;
         n_checks++; if (f !== 8'(4 + k)) $display("FAIL gaps_frame_id%0d: got %0d expected %0d", k, f, 4 + k); else n_pass++;
`ifdef MASK_CENTROID_BBOX_EN
         n_checks++; if (bb !== ebb[k]) $display("FAIL gaps_bbox%0d: got %h expected %h", k, bb, ebb[k]); else n_pass++;
`endif
      end
      n_checks++; if (busy !== 1'b0) $display("FAIL gaps_busy_after: got %b expected 0", busy); else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      bit ok; int cyc, rd0;
      logic [CNT_W-1:0] c; logic [SUM_W-1:0] sx, sy; logic [7:0] f; logic [19:0] bb;
      clear_recs();
      for (int i = 0; i < NPIX; i++) img[i] = 8'hFF;
      rd0 = rd_count;
      push_frame();
      cyc = 0;
      while (rd_count - rd0 < 500 && cyc < TMO) begin
         @(negedge clk);
         cyc++;
      end
      n_checks++; if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b expected 1", busy); else n_pass++;
      @(posedge clk); #2;
      rst_n = 1'b0;
      fifo_q.delete();
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy_reset: got %b expected 0", busy); else n_pass++;
      n_checks++; if (res_frame_id !== 8'd0) $display("FAIL mid_frame_id_reset: got %0d expected 0", res_frame_id); else n_pass++;
      @(posedge clk); #1 rst_n = 1'b1;
      for (int i = 0; i < NPIX; i++) img[i] = 8'h00;
      img[4*IMG_W + 3] = 8'h80;
      img[NPIX - 1]    = 8'h02;
      img[0]           = 8'h10;
      push_frame();
      wait_records(1, ok);
      n_checks++; if (!ok) $display("FAIL mid_timeout: got no record, expected 1"); else n_pass++;
      pop_rec(c, sx, sy, f, bb);
      n_checks++; if (c !== 11'd3) $display("FAIL mid_count: got %0d expected 3", c); else n_pass++;
      n_checks++; if (sx !== 20'd34) $display("FAIL mid_sum_x: got %0d expected 34", sx); else n_pass++;
      n_checks++; if (sy !== 20'd35) $display("FAIL mid_sum_y: got %0d expected 35", sy); else n_pass++;
      n_checks++; if (f !== 8'd0) $display("FAIL mid_frame_id: got %0d expected 0", f); else n_pass++;
`ifdef MASK_CENTROID_BBOX_EN
      n_checks++; if (bb !== {5'd0, 5'd31, 5'd0, 5'd31}) $display("FAIL mid_bbox: got %h expected %h", bb, {5'd0, 5'd31, 5'd0, 5'd31}); else n_pass++;
`endif
   endtask

   initial begin
      test_reset();
      test_zero_frame();
      test_full_frame();
      test_single_pixel();
      test_hold();
      test_gaps();
      test_reset_mid_frame();
      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mask_centroid_acc.md
Name: mask_centroid_acc

Overview:
- Downstream consumer of the morphology pipeline's 8-bit binary mask stream, read from the pipeline's destination FIFO.
- Tracks raster x/y position over an IMG_W x IMG_H frame and accumulates foreground pixel count, sum of x and sum of y.
- At each frame end it posts one result record over a valid/ready handshake; the host computes the centroid by dividing the sums by the count.

Parameters:
- IMG_W, 32, pixels per line.
- IMG_H, 32, lines per frame.
- CNT_W, 11, width of the pixel-count field; must hold IMG_W*IMG_H.
- SUM_W, 20, width of sum_x and sum_y; must hold (IMG_W-1)*IMG_W*IMG_H.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_rst_n  in  1  synchronous active-low clear; same effect as rst_n, taken at the clock edge
- mask_fifo_rd_en  out  1  FIFO read strobe
- mask_fifo_dout  in  8  mask byte; valid the cycle after rd_en (standard FIFO, 1-cycle read latency)
- mask_fifo_empty  in  1  FIFO empty
- res_valid  out  1  result record valid
- res_ready  in  1  host accepts the record
- res_count  out  CNT_W  foreground pixel count
- res_sum_x  out  SUM_W  sum of x over foreground pixels
- res_sum_y  out  SUM_W  sum of y over foreground pixels
- res_frame_id  out  8  frame counter, wraps 255 -> 0
- busy  out  1  high while the current frame has consumed at least 1 pixel

Behaviour:
- Reset (rst_n low, or s_rst_n low at an edge):
  - All outputs 0.
  - x, y, accumulators, frame_id and rd_pending cleared.
  - Reset mid-frame discards the partial frame; the next read starts at x=0, y=0.
- Hold: hold = res_valid & ~res_ready.
- Read strobe: mask_fifo_rd_en = ~mask_fifo_empty & ~hold (combinational). rd_pending <= mask_fifo_rd_en.
- Beat processing: when rd_pending=1, mask_fifo_dout is the pixel at (x,y).
  - Foreground means dout != 0; any nonzero value counts.
  - Foreground: count += 1, sum_x += x, sum_y += y.
  - Then x += 1. At x == IMG_W-1: x <= 0, y += 1.
  - At x == IMG_W-1 and y == IMG_H-1 (frame end):
    - Load res_* from the accumulators, including the final beat's contribution.
    - res_valid <= 1; res_frame_id <= frame_id; frame_id += 1.
    - Accumulators, x and y <= 0 in the same cycle.
- Latency: res_valid rises on the clock edge that consumes the last beat, i.e. 2 cycles after the final rd_en.
- Handshake:
  - res_* stay stable while res_valid=1.
  - res_valid clears on the edge where res_valid & res_ready.
- Hold and in-flight beats:
  - A beat already requested (rd_pending) when hold asserts is still consumed into the new frame.
  - A second frame end while res_valid=1 cannot occur, because hold blocks reads until acceptance and IMG_W*IMG_H > 1 beat.
- Simultaneous events: res_ready accepted in the same cycle a frame ends is impossible, since reads are blocked during hold.
- busy = (x != 0) | (y != 0).
- Empty FIFO:
  - No read and no state change.
  - Gaps between beats are allowed at any point.
- Arithmetic: all accumulation unsigned with no saturation; SUM_W/CNT_W sizing per the Parameters section guarantees no overflow.

Optional Feature:
- Macro: MASK_CENTROID_BBOX_EN.
- When defined:
  - Adds outputs res_xmin, res_xmax (clog2(IMG_W) bits) and res_ymin, res_ymax (clog2(IMG_H) bits).
  - Running min/max over foreground pixels; they reset per frame to min = all-ones, max = 0, loaded with the other res_* fields.
  - With count = 0: xmin = ymin = all-ones, xmax = ymax = 0.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset then one all-zero 32x32 frame, res_ready=1 -> res_valid pulses 1 cycle; count=0, sum_x=0, sum_y=0, frame_id=0.
- All-0xFF frame -> count=1024, sum_x=15872, sum_y=15872; BBOX_EN: xmin=0, xmax=31, ymin=0, ymax=31.
- Single pixel 0x01 at (5,7), rest 0, then second identical frame -> count=1, sum_x=5, sum_y=7, frame_id=0 then 1; BBOX_EN: bbox (5,5,7,7).
- res_ready=0 for 50 cycles after frame end, FIFO kept non-empty -> at most 1 extra beat read, res_* stable, rd_en low; after res_ready=1 reads resume and the next frame's record is correct.
- Random empty gaps (30% duty) over 3 frames with random masks -> records match the reference model; no beat lost or duplicated.
- rst_n low at pixel 500 of a frame, then a full frame -> the record reflects only the post-reset frame; frame_id=0.
